axi_rd_arbiter: RTL

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin N:1 AXI read-channel arbiter with exactly one burst outstanding downstream.
// The downstream beat count is checked against the granted arlen and mismatches are flagged.
module axi_rd_arbiter #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32
) (
   input  logic                            i_aclk,
   input  logic                            i_areset_n,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   s_araddr,
   input  logic [NUM_MASTERS*8-1:0]        s_arlen,
   input  logic [NUM_MASTERS-1:0]          s_arvalid,
   output logic [NUM_MASTERS-1:0]          s_arready,
   output logic [DATA_W-1:0]               s_rdata,
   output logic [1:0]                      s_rresp,
   output logic                            s_rlast,
   output logic [NUM_MASTERS-1:0]          s_rvalid,
   input  logic [NUM_MASTERS-1:0]          s_rready,
   output logic [ADDR_W-1:0]               m_araddr,
   output logic [7:0]                      m_arlen,
   output logic                            m_arvalid,
   input  logic                            m_arready,
   input  logic [DATA_W-1:0]               m_rdata,
   input  logic [1:0]                      m_rresp,
   input  logic                            m_rlast,
   input  logic                            m_rvalid,
   output logic                            m_rready,
   output logic                            o_len_err,
   output logic [$clog2(NUM_MASTERS)-1:0]  o_grant
);

   localparam int unsigned GntW = $clog2(NUM_MASTERS);
   localparam logic [GntW-1:0] RstGrant = GntW'(NUM_MASTERS - 1);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e                    r_state;
   state_e                    w_state_d;
   logic [GntW-1:0]           r_grant;
   logic [GntW-1:0]           r_last_grant;
   logic [ADDR_W-1:0]         r_addr;
   logic [7:0]                r_len;
   logic [8:0]                r_beats;
   logic                      r_over;
   logic                      r_len_err;

   logic                      w_any;
   logic                      w_beat;
   logic                      w_sel_rready;
   logic                      w_len_err_d;
   logic                      w_over_set;
   logic [GntW:0]             w_shamt;
   logic [GntW:0]             w_sum;
   logic [GntW-1:0]           w_off;
   logic [GntW-1:0]           w_pick;
   logic [2*NUM_MASTERS-1:0]  w_dbl;
   logic [NUM_MASTERS-1:0]    w_rot;
   logic [NUM_MASTERS-1:0]    w_pick_oh;
   logic [NUM_MASTERS-1:0]    w_gnt_oh;
   logic [ADDR_W-1:0]         w_sel_addr;
   logic [7:0]                w_sel_len;

   assign w_any = |s_arvalid;

   // Rotate requests so bit 0 is the master after the last grant; first set bit wins.
   always_comb begin
      w_shamt = {1'b0, r_last_grant} + (GntW+1)'(1);
      w_dbl   = {s_arvalid, s_arvalid} >> w_shamt;
      w_rot   = w_dbl[NUM_MASTERS-1:0];
      w_off   = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = GntW'(i);
         end
      end
      w_sum = w_shamt + {1'b0, w_off};
      if (w_sum >= (GntW+1)'(NUM_MASTERS)) begin
         w_sum = w_sum - (GntW+1)'(NUM_MASTERS);
      end
      w_pick = w_sum[GntW-1:0];
   end

   always_comb begin
      w_pick_oh  = '0;
      w_gnt_oh   = '0;
      w_sel_addr = '0;
      w_sel_len  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_pick_oh[i] = (w_pick == GntW'(i));
         w_gnt_oh[i]  = (r_grant == GntW'(i));
         if (w_pick_oh[i]) begin
            w_sel_addr = s_araddr[i*ADDR_W +: ADDR_W];
            w_sel_len  = s_arlen[i*8 +: 8];
         end
      end
   end

   assign w_sel_rready = |(s_rready & w_gnt_oh);
   assign w_beat       = (r_state == StData) && m_rvalid && w_sel_rready;

   // An overrun is flagged once; the closing rlast beat then stays silent.
   always_comb begin
      w_len_err_d = 1'b0;
      w_over_set  = 1'b0;
      if (w_beat) begin
         if (m_rlast) begin
            w_len_err_d = !r_over && (r_beats != {1'b0, r_len});
         end else if (!r_over && (r_beats == {1'b0, r_len})) begin
            w_len_err_d = 1'b1;
            w_over_set  = 1'b1;
         end
      end
   end

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle: begin
            if (w_any) begin
               w_state_d = StAddr;
            end
         end
         StAddr: begin
            if (m_arready) begin
               w_state_d = StData;
            end
         end
         StData: begin
            if (w_beat && m_rlast) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_comb begin
      s_arready = '0;
      s_rvalid  = '0;
      s_rdata   = '0;
      s_rresp   = '0;
      s_rlast   = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_areset_n && w_any) begin
               s_arready = w_pick_oh;
            end
         end
         StAddr: m_arvalid = 1'b1;
         StData: begin
            m_rready = w_sel_rready;
            s_rvalid = w_gnt_oh & {NUM_MASTERS{m_rvalid}};
            s_rdata  = m_rdata;
            s_rresp  = m_rresp;
            s_rlast  = m_rlast;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_grant      <= RstGrant;
         r_last_grant <= RstGrant;
         r_addr       <= '0;
         r_len        <= '0;
         r_beats      <= '0;
         r_over       <= 1'b0;
         r_len_err    <= 1'b0;
      end else begin
         r_len_err <= w_len_err_d;
         if ((r_state == StIdle) && w_any) begin
            r_grant <= w_pick;
            r_addr  <= w_sel_addr;
            r_len   <= w_sel_len;
         end
         if ((r_state == StAddr) && m_arready) begin
            r_beats <= '0;
            r_over  <= 1'b0;
         end else if (w_beat) begin
            r_beats <= r_beats + 9'd1;
            if (w_over_set) begin
               r_over <= 1'b1;
            end
         end
         if (w_beat && m_rlast) begin
            r_last_grant <= r_grant;
         end
      end
   end

   assign m_araddr  = r_addr;
   assign m_arlen   = r_len;
   assign o_len_err = r_len_err;
   assign o_grant   = r_grant;

endmodule
